// File: rtl/snare_recorder.sv
// Writes a signed 16-bit sample stream into the snare sample RAM at addresses 0..MAXCOUNT.
// Define RECORDER_TRIGGER_EN to build the ARMED state and the |sample| >= THRESHOLD start trigger.
module snare_recorder #(
  parameter logic [14:0] MAXCOUNT  = 15'd16481,
  parameter logic [14:0] THRESHOLD = 15'd2048
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic [14:0] length
);

  typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;

  state_t      state;
  logic [14:0] cnt;
  logic        accept;

`ifdef RECORDER_TRIGGER_EN
  logic [15:0] neg;
  logic [14:0] mag;

  // -32768 has no positive counterpart, so it saturates to 32767
  always_comb begin
    neg = -sample_in;
    if (!sample_in[15])           mag = sample_in[14:0];
    else if (sample_in == 16'h8000) mag = 15'h7fff;
    else                          mag = neg[14:0];
  end

  assign accept = sample_valid &&
                  (state == RECORD || (state == ARMED && mag >= THRESHOLD));
`else
  logic unused_thr;
  assign unused_thr = ^THRESHOLD;
  assign accept     = sample_valid && state == RECORD;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      length  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (abort && (state == ARMED || state == RECORD || start)) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start && (state == IDLE || state == DONE)) begin
`ifdef RECORDER_TRIGGER_EN
        state <= ARMED;
`else
        state <= RECORD;
`endif
        cnt    <= '0;
        length <= '0;
        busy   <= 1'b1;
        done   <= 1'b0;
      end else if (accept) begin
        // cnt is still 0 in ARMED, so the triggering sample lands at word 0
        wr_en   <= 1'b1;
        wr_addr <= cnt;
        wr_data <= sample_in;
        length  <= cnt + 15'd1;
        if (cnt == MAXCOUNT) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RECORD;
          cnt   <= cnt + 15'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snare_recorder.sv
// Directed bench for snare_recorder: reset, full capture, restart with gaps, abort,
// and (with RECORDER_TRIGGER_EN) trigger threshold and saturation cases.
module tb_snare_recorder;

  localparam logic [14:0] MAXC = 15'd16481;

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic [14:0] wr_addr, length;
  logic [15:0] wr_data;
  logic        wr_en, busy, done;
  logic [31:0] wrw, st;
  int          n_chk = 0, n_fail = 0;
  int          first = 0;

  snare_recorder #(.MAXCOUNT(MAXC), .THRESHOLD(15'd2048)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .length(length)
  );

  assign wrw = {wr_en, wr_addr, wr_data};
  assign st  = {15'd0, busy, done, length};

`ifdef RECORDER_TRIGGER_EN
  logic [14:0] s_addr, s_len;
  logic [15:0] s_data;
  logic        s_en, s_busy, s_done;
  logic [31:0] s_wrw;

  snare_recorder #(.MAXCOUNT(MAXC), .THRESHOLD(15'd32767)) u_sat (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .wr_addr(s_addr), .wr_data(s_data), .wr_en(s_en),
    .busy(s_busy), .done(s_done), .length(s_len)
  );
  assign s_wrw = {s_en, s_addr, s_data};
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stv(input logic b, input logic d, input logic [14:0] l);
    return {15'd0, b, d, l};
  endfunction

  function automatic logic [31:0] wv(input logic e, input int a, input logic [15:0] d);
    return {e, 15'(a), d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Start a capture; the trigger build needs a loud sample first, which becomes word 0
  task automatic arm;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_state", st, stv(1'b1, 1'b0, 15'd0));
`ifdef RECORDER_TRIGGER_EN
    send(16'h7fff);
    chk("arm_trig", wrw, wv(1'b1, 0, 16'h7fff));
    first = 1;
`else
    first = 0;
`endif
  endtask

  initial begin
    #1;
    chk("rst_wr", wrw, 32'd0);
    chk("rst_st", st, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

`ifdef RECORDER_TRIGGER_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("trg_busy", st, stv(1'b1, 1'b0, 15'd0));
    send(16'd100);
    chk("trg_below1", {31'd0, wr_en}, 32'd0);
    send(16'hf801);  // -2047
    chk("trg_below2", {31'd0, wr_en}, 32'd0);
    send(16'hf800);  // -2048
    chk("trg_word0", wrw, wv(1'b1, 0, 16'hf800));
    send(16'd5);
    chk("trg_word1", wrw, wv(1'b1, 1, 16'd5));
    chk("trg_len", st, stv(1'b1, 1'b0, 15'd2));
    abort = 1'b1;
    tick();
    abort = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    send(16'h7ffe);
    chk("sat_below", {31'd0, s_en}, 32'd0);
    send(16'h8000);
    chk("sat_word0", s_wrw, wv(1'b1, 0, 16'h8000));
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // asynchronous reset in the middle of a capture
    arm();
    for (int k = first; k <= 100; k++) send(16'(k + 1000));
    chk("mid_wr", wrw, wv(1'b1, 100, 16'd1100));
    chk("mid_st", st, stv(1'b1, 1'b0, 15'd101));
    #2 resetn = 1'b0;
    #1;
    chk("async_wr", wrw, 32'd0);
    chk("async_st", st, 32'd0);
    #3 resetn = 1'b1;
    tick();
    send(16'h7fff);
    chk("post_rst_wr", wrw, 32'd0);
    chk("post_rst_st", st, 32'd0);

    // full capture, back-to-back samples, value = index
    arm();
    sample_valid = 1'b1;
    for (int k = first; k <= int'(MAXC); k++) begin
      sample_in = 16'(k);
      tick();
      chk("full_wr", wrw, wv(1'b1, k, 16'(k)));
    end
    chk("full_done", st, stv(1'b0, 1'b1, 15'd16482));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_no_wr", wrw, wv(1'b0, int'(MAXC), 16'(MAXC)));
      chk("full_hold", st, stv(1'b0, 1'b1, 15'd16482));
    end
    sample_valid = 1'b0;

    // restart from DONE with one sample every third cycle
    arm();
    for (int i = first; i < first + 4; i++) begin
      send(16'(i + 200));
      chk("gap_wr", wrw, wv(1'b1, i, 16'(i + 200)));
      tick();
      chk("gap_idle1", wrw, wv(1'b0, i, 16'(i + 200)));
      tick();
      chk("gap_idle2", wrw, wv(1'b0, i, 16'(i + 200)));
    end
    for (int i = first + 4; i < 10; i++) begin
      send(16'(i + 300));
      chk("pre_abort_wr", wrw, wv(1'b1, i, 16'(i + 300)));
    end
    chk("pre_abort_st", st, stv(1'b1, 1'b0, 15'd10));

    // abort beats start in the same cycle; the sample with it is dropped
    abort        = 1'b1;
    start        = 1'b1;
    sample_valid = 1'b1;
    sample_in    = 16'h1234;
    tick();
    abort        = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    chk("abort_st", st, stv(1'b0, 1'b0, 15'd10));
    chk("abort_wr", {31'd0, wr_en}, 32'd0);
    send(16'h7fff);
    chk("abort_idle_wr", {31'd0, wr_en}, 32'd0);
    send(16'h8000);
    chk("abort_idle_st", st, stv(1'b0, 1'b0, 15'd10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snare_recorder.md
# snare_recorder

Captures a signed 16-bit audio stream into the snare sample RAM, writing addresses 0 to MAXCOUNT in order. It is the writer for the RAM that the snare playback counter reads. The block sits between the audio codec's input sample stream and the RAM write port. A small FSM arms on `start`, optionally waits for a level trigger, records one word per accepted sample, and reports the captured length.

## Interface

Parameters:
- `MAXCOUNT`, default 15'd16481. Last RAM address written; a full capture is MAXCOUNT+1 words.
- `THRESHOLD`, default 15'd2048. Trigger level on |sample|. Used only with `RECORDER_TRIGGER_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a capture.
- `abort`  in  1  stop the capture immediately.
- `sample_in`  in  16  signed two's-complement audio sample.
- `sample_valid`  in  1  `sample_in` is valid this cycle; at most one sample per cycle.
- `wr_addr`  out  15  RAM write address.
- `wr_data`  out  16  RAM write data.
- `wr_en`  out  1  RAM write strobe; one word per high cycle.
- `busy`  out  1  high in ARMED or RECORD.
- `done`  out  1  high while in DONE.
- `length`  out  15  number of words written by the last or current capture.

## Operation

States: IDLE, ARMED, RECORD, DONE. All outputs are registered.

- **Reset.** State goes to IDLE. `wr_addr`, `wr_data`, `length` = 0. `wr_en`, `busy`, `done` = 0.
- **IDLE or DONE, `start`=1.** Go to ARMED (trigger build) or RECORD (no trigger). Clear the internal address counter and `length` to 0. `done` drops.
- **ARMED.**
  - For each valid sample, compute |sample_in| with saturation: -32768 maps to 32767.
  - If |sample_in| ≥ THRESHOLD, go to RECORD. The triggering sample itself is written as word 0.
  - Samples below the threshold are discarded.
- **RECORD.**
  - Each valid sample is accepted. On the next cycle, `wr_en`=1, `wr_addr`=counter, `wr_data`=sample, and `length`=counter+1. The counter then increments.
  - When the word at address MAXCOUNT is written, go to DONE in that same cycle. The counter does not wrap, and no write occurs past MAXCOUNT.
- **DONE.** Hold `length` (MAXCOUNT+1 after a full capture). Samples are ignored. `start` re-arms.
- **`abort`** in ARMED or RECORD: go to IDLE. `length` holds the count written so far. A write already registered for this cycle still completes. Samples are not accepted in the abort cycle.
- **`abort` and `start` in the same cycle:** `abort` wins; the state is IDLE.
- **`start` in ARMED or RECORD:** ignored.
- **`sample_valid` outside ARMED or RECORD:** ignored. `wr_en` stays 0.

## Timing

- Sample-to-write latency is 1 cycle: a sample accepted at edge N produces `wr_en` high from N to N+1.
- Back-to-back `sample_valid` gives `wr_en` high on consecutive cycles with consecutive addresses.
- `wr_addr` and `wr_data` hold their last values when `wr_en`=0.
- `start` to `busy` high: 1 cycle.
- The final write and `done` rise are on the same edge; `busy` falls on that edge too.
- `resetn` asserted mid-capture forces reset values asynchronously. RAM contents already written are undefined to later readers.

## Configuration

- **`RECORDER_TRIGGER_EN` defined:** the ARMED state and the absolute-value comparator are built. `start` goes to ARMED, and `busy` is high while waiting for the trigger.
- **`RECORDER_TRIGGER_EN` undefined:** ARMED is not implemented. `start` goes straight to RECORD, and the first valid sample after `start` is word 0. `THRESHOLD` is unused.

## Test plan

- **Reset.** Assert `resetn`=0 mid-RECORD at address 100. Require all outputs at reset values immediately, with no clock needed. After release, the state is IDLE.
- **Full capture.** Trigger off, `start`, then 16482 back-to-back samples with value = index. Require `wr_data` at address k to equal k. Require `done` to rise with the write to address 16481, `length`=16482, and no further `wr_en`.
- **Trigger.** Trigger on, THRESHOLD=2048. Send samples 100, -2047, -2048, 5. Require nothing written for the first two samples. Then require address 0 = -2048 and address 1 = 5.
- **Saturation.** Trigger on, THRESHOLD=32767. Send sample -32768. Require a trigger, with address 0 = 16'h8000.
- **Abort.** Abort after 10 writes, with `start` in the same cycle. Require the state to go to IDLE, `length`=10, `busy`=0, and no further writes.
- **Restart and gaps.** From DONE, `start`, then send valid samples every 3rd cycle. Require addresses to restart at 0, `wr_en` pulses spaced 3 cycles apart, and `done` low from the cycle after `start`.
